// File: rtl/jtframe_pocket_cmd_if.sv
// rtl/jtframe_pocket_cmd_if.sv - bridge window and core command/parameter/response signal bundle
interface jtframe_pocket_cmd_if;
    logic [31:0] bridge_addr;
    logic        bridge_rd;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic [31:0] cmd_bridge_rd_data;
    logic        cmd_valid;
    logic [15:0] cmd_code;
    logic        cmd_ready;
    logic [5:0]  prm_addr;
    logic [31:0] prm_dout;
    logic        rsp_valid;
    logic [15:0] rsp_result;

    modport master (
        output bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
        output cmd_ready, prm_addr, rsp_valid, rsp_result,
        input  cmd_bridge_rd_data, cmd_valid, cmd_code, prm_dout
    );

    modport slave (
        input  bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
        input  cmd_ready, prm_addr, rsp_valid, rsp_result,
        output cmd_bridge_rd_data, cmd_valid, cmd_code, prm_dout
    );
endinterface

// File: rtl/jtframe_pocket_cmd.sv
// rtl/jtframe_pocket_cmd.sv - host command/status endpoint with parameter RAM and core handshake
module jtframe_pocket_cmd #(
    parameter logic [23:0] TIMEOUT = 24'd7_425_000,
    parameter logic [15:0] MAGIC   = 16'h434D
) (
    input  logic                    clk,
    input  logic                    rst,
    jtframe_pocket_cmd_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_EXEC, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [15:0] cmd_code_q, cmd_code_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic [15:0] result_q, result_d;
    logic [23:0] timer_q, timer_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] prm_dout_q, prm_dout_d;

    logic [31:0] prm_mem [0:63];

    logic        sel;
    logic [23:0] off;
    logic        is_cmd, is_status, is_prm;
    logic [5:0]  host_idx;
    logic        cmd_wr, prm_wr, prm_wr_ok;
    logic [15:0] wr_code;
    logic        busy, idle_or_done, timed_out;
    logic [31:0] status;
    logic        unused_sigs;

    assign sel       = bus.bridge_addr[31:24] == 8'hF8;
    assign off       = bus.bridge_addr[23:0];
    assign is_cmd    = sel && (off == 24'h000000);
    assign is_status = sel && (off == 24'h000004);
    assign is_prm    = sel && (off[23:8] == 16'h0001);
    assign host_idx  = off[7:2];
    assign wr_code   = bus.bridge_wr_data[15:0];

    assign cmd_wr = bus.bridge_wr && is_cmd && (bus.bridge_wr_data[31:16] == MAGIC);
    assign prm_wr = bus.bridge_wr && is_prm;

    assign busy         = (state_q == S_PEND) || (state_q == S_EXEC);
    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign prm_wr_ok    = prm_wr && idle_or_done;
    assign timed_out    = timer_q == (TIMEOUT - 24'd1);

    assign status = {8'hA5, 4'h0, ovr_q, err_q, done_q, busy, result_q};

    // Read data follows the address, not bridge_rd, so the strobe is only informational.
    assign unused_sigs = bus.bridge_rd;

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        done_d      = done_q;
        err_d       = err_q;
        ovr_d       = ovr_q;
        result_d    = result_q;
        timer_d     = timer_q;

        // A host command write pre-empts any core event in the same cycle.
        if (cmd_wr) begin
            if (wr_code == 16'h0000) begin
                state_d     = S_IDLE;
                cmd_valid_d = 1'b0;
                done_d      = 1'b0;
                err_d       = 1'b0;
                timer_d     = 24'd0;
            end else if (idle_or_done) begin
                state_d     = S_PEND;
                cmd_valid_d = 1'b1;
                cmd_code_d  = wr_code;
                ovr_d       = 1'b0;
                err_d       = 1'b0;
                done_d      = 1'b0;
                result_d    = 16'h0000;
                timer_d     = 24'd0;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_PEND: begin
                    timer_d = timer_q + 24'd1;
                    if (bus.cmd_ready && bus.rsp_valid) begin
                        state_d     = S_DONE;
                        cmd_valid_d = 1'b0;
                        result_d    = bus.rsp_result;
                        done_d      = 1'b1;
                    end else if (timed_out) begin
                        state_d     = S_DONE;
                        cmd_valid_d = 1'b0;
                        result_d    = 16'hFFFF;
                        err_d       = 1'b1;
                        done_d      = 1'b1;
                    end else if (bus.cmd_ready) begin
                        state_d     = S_EXEC;
                        cmd_valid_d = 1'b0;
                    end
                end
                S_EXEC: begin
                    timer_d = timer_q + 24'd1;
                    if (bus.rsp_valid) begin
                        state_d  = S_DONE;
                        result_d = bus.rsp_result;
                        done_d   = 1'b1;
                    end else if (timed_out) begin
                        state_d     = S_DONE;
                        cmd_valid_d = 1'b0;
                        result_d    = 16'hFFFF;
                        err_d       = 1'b1;
                        done_d      = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (prm_wr && !idle_or_done) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = 32'h0;
        if (is_status) begin
            rd_data_d = status;
        end else if (is_prm) begin
            rd_data_d = prm_mem[host_idx];
        end
        prm_dout_d = prm_mem[bus.prm_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 16'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            result_q    <= 16'h0;
            timer_q     <= 24'd0;
            rd_data_q   <= 32'h0;
            prm_dout_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            result_q    <= result_d;
            timer_q     <= timer_d;
            rd_data_q   <= rd_data_d;
            prm_dout_q  <= prm_dout_d;
        end
    end

    // Parameter contents survive reset; reads above see the pre-write word.
    always_ff @(posedge clk) begin
        if (prm_wr_ok) begin
            prm_mem[host_idx] <= bus.bridge_wr_data;
        end
    end

    assign bus.cmd_bridge_rd_data = rd_data_q;
    assign bus.cmd_valid          = cmd_valid_q;
    assign bus.cmd_code           = cmd_code_q;
    assign bus.prm_dout           = prm_dout_q;
endmodule

// File: tb/tb_jtframe_pocket_cmd.sv
// tb/tb_jtframe_pocket_cmd.sv - directed self-checking bench for jtframe_pocket_cmd
module tb_jtframe_pocket_cmd;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    jtframe_pocket_cmd_if bus ();

    jtframe_pocket_cmd #(
        .TIMEOUT (24'd16),
        .MAGIC   (16'h434D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bwrite(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.bridge_addr    = addr;
        bus.bridge_wr_data = data;
        bus.bridge_wr      = 1'b1;
        @(posedge clk);
        #1;
        bus.bridge_wr      = 1'b0;
    endtask

    task automatic bread(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.bridge_addr = addr;
        bus.bridge_rd   = 1'b1;
        @(posedge clk);
        #1;
        bus.bridge_rd   = 1'b0;
        data = bus.cmd_bridge_rd_data;
    endtask

    task automatic ready_pulse();
        @(negedge clk);
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_ready = 1'b0;
    endtask

    task automatic rsp_pulse(input logic [15:0] res, input logic with_ready);
        @(negedge clk);
        bus.rsp_valid  = 1'b1;
        bus.rsp_result = res;
        bus.cmd_ready  = with_ready;
        @(posedge clk);
        #1;
        bus.rsp_valid  = 1'b0;
        bus.cmd_ready  = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.bridge_addr    = 32'h0;
        bus.bridge_rd      = 1'b0;
        bus.bridge_wr      = 1'b0;
        bus.bridge_wr_data = 32'h0;
        bus.cmd_ready      = 1'b0;
        bus.prm_addr       = 6'd0;
        bus.rsp_valid      = 1'b0;
        bus.rsp_result     = 16'h0;

        tick();
        tick();
        chk("rst_cmd_valid", {31'h0, bus.cmd_valid}, 32'h0);
        chk("rst_cmd_code", {16'h0, bus.cmd_code}, 32'h0);
        chk("rst_prm_dout", bus.prm_dout, 32'h0);
        chk("rst_rd_data", bus.cmd_bridge_rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        bread(32'hF800_0004, rd);
        chk("status_reset", rd, 32'hA500_0000);
        bread(32'hF800_0200, rd);
        chk("unmapped_in_window", rd, 32'h0);
        bread(32'h1000_0000, rd);
        chk("out_of_window", rd, 32'h0);

        bwrite(32'hF800_010C, 32'hDEAD_BEEF);
        bread(32'hF800_010C, rd);
        chk("prm3_bridge_rd", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.prm_addr = 6'd3;
        tick();
        chk("prm3_core_rd", bus.prm_dout, 32'hDEAD_BEEF);

        // Same-address host write and core read: core sees old word first.
        @(negedge clk);
        bus.bridge_addr    = 32'hF800_010C;
        bus.bridge_wr_data = 32'h1111_2222;
        bus.bridge_wr      = 1'b1;
        tick();
        bus.bridge_wr = 1'b0;
        chk("prm_rw_collide_old", bus.prm_dout, 32'hDEAD_BEEF);
        tick();
        chk("prm_rw_collide_new", bus.prm_dout, 32'h1111_2222);

        bwrite(32'hF800_0000, 32'h434D_0012);
        chk("cmd1_valid", {31'h0, bus.cmd_valid}, 32'h1);
        chk("cmd1_code", {16'h0, bus.cmd_code}, 32'h0000_0012);
        bread(32'hF800_0004, rd);
        chk("cmd1_busy", rd, 32'hA501_0000);
        ready_pulse();
        chk("cmd1_valid_drop", {31'h0, bus.cmd_valid}, 32'h0);
        rsp_pulse(16'h00AB, 1'b0);
        bread(32'hF800_0004, rd);
        chk("cmd1_done", rd, 32'hA502_00AB);

        bwrite(32'hF800_0000, 32'h434D_0021);
        ready_pulse();
        bwrite(32'hF800_0000, 32'h1234_0005);
        chk("badmagic_code", {16'h0, bus.cmd_code}, 32'h0000_0021);
        bread(32'hF800_0004, rd);
        chk("badmagic_status", rd, 32'hA501_0000);
        bwrite(32'hF800_010C, 32'h5555_5555);
        bread(32'hF800_0004, rd);
        chk("prm_drop_ovr", rd, 32'hA509_0000);
        bwrite(32'hF800_0000, 32'h434D_0007);
        chk("cmd_in_exec_code", {16'h0, bus.cmd_code}, 32'h0000_0021);
        bread(32'hF800_010C, rd);
        chk("prm_drop_data", rd, 32'h1111_2222);
        bwrite(32'hF800_0000, 32'h434D_0000);
        bread(32'hF800_0004, rd);
        chk("abort_exec_status", rd, 32'hA508_0000);

        bwrite(32'hF800_0000, 32'h434D_0033);
        for (int i = 0; i < 15; i++) tick();
        chk("timeout_pre_valid", {31'h0, bus.cmd_valid}, 32'h1);
        tick();
        chk("timeout_valid", {31'h0, bus.cmd_valid}, 32'h0);
        bread(32'hF800_0004, rd);
        chk("timeout_status", rd, 32'hA506_FFFF);

        bwrite(32'hF800_0000, 32'h434D_0044);
        for (int i = 0; i < 15; i++) tick();
        rsp_pulse(16'h0BEE, 1'b1);
        chk("race_valid", {31'h0, bus.cmd_valid}, 32'h0);
        bread(32'hF800_0004, rd);
        chk("race_status", rd, 32'hA502_0BEE);

        bwrite(32'hF800_0000, 32'h434D_0055);
        chk("pend_valid", {31'h0, bus.cmd_valid}, 32'h1);
        bwrite(32'hF800_0000, 32'h434D_0000);
        chk("abort_pend_valid", {31'h0, bus.cmd_valid}, 32'h0);
        bread(32'hF800_0004, rd);
        chk("abort_pend_status", rd, 32'hA500_0000);

        bwrite(32'hF800_0000, 32'h434D_0066);
        ready_pulse();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        rsp_pulse(16'h1234, 1'b0);
        bread(32'hF800_0004, rd);
        chk("rst_exec_status", rd, 32'hA500_0000);
        chk("rst_exec_valid", {31'h0, bus.cmd_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
